pe_mac_array_cell: RTL and testbench
====================================

# pe_mac_array_cell

Parametrised processing element for the convolution datapath. It is the next generation of the 8-bit PE: configurable data and accumulator widths, signed arithmetic, saturating accumulation, and valid-qualified systolic partial-sum chaining. It tiles into the weight-stationary systolic array and can also run stand-alone as a single MAC unit. Activations move left→right through `in_data_o`; partial sums move top→bottom through `psum_o`.

## Interface
- `DATA_W`, default 8: activation, weight and filter width, signed two's complement.
- `ACC_W`, default 20: accumulator and partial-sum width. Must be ≥ 2*DATA_W.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `mode_i`  input  2  operating mode: 0 SINGLE, 1 SA, 2 LOAD, 3 IDLE.
- `in_valid`  input  1  qualifies `in_data`, `in_filter` and `psum_i` this cycle.
- `in_data`  input  DATA_W  activation input.
- `in_filter`  input  DATA_W  filter operand in SINGLE mode; weight value in LOAD mode.
- `psum_i`  input  ACC_W  partial sum from the PE above (SA mode).
- `acc_clr`  input  1  synchronous clear of the accumulator and the `sat` flag.
- `in_data_o`  output  DATA_W  registered `in_data`, forwarded to the right neighbour.
- `in_valid_o`  output  1  registered `in_valid`, forwarded with `in_data_o`.
- `psum_o`  output  ACC_W  registered SA partial sum, sent to the PE below.
- `pe_out`  output  ACC_W  registered result; meaning depends on the mode.
- `out_valid`  output  1  one-cycle pulse; `pe_out` was updated this cycle.
- `sat`  output  1  sticky flag: the accumulator or the partial sum saturated.

## Operation
- Internal registers: `weight` (DATA_W), `acc` (ACC_W), `psum` (ACC_W), `fwd_data`, `fwd_valid`, `pe_out`, `out_valid`, `sat`, `mode_q`.
- Product: `prod = in_data * operand`, full 2*DATA_W signed result, sign-extended to ACC_W. The operand is `in_filter` in SINGLE mode and `weight` in SA mode.
- Saturating add: if the ACC_W+1-bit signed sum exceeds the range, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and set `sat`. There is no wrap-around.
- **SINGLE (0):** when `in_valid`, `acc <= sat_add(acc, prod)`. `pe_out` shows the new `acc`.
- **SA (1):** when `in_valid`, `psum <= sat_add(psum_i, prod)`. `pe_out` shows the same value. `acc` is untouched.
- **LOAD (2):** when `in_valid`, `weight <= in_filter`. `pe_out` shows `weight` sign-extended to ACC_W.
- **IDLE (3):** all registers hold, including `fwd_data`/`fwd_valid`. `out_valid` = 0. `acc_clr` is still honoured.
- Forwarding: in modes 0–2, `fwd_data <= in_data` and `fwd_valid <= in_valid` every cycle, regardless of `in_valid`.
- `acc_clr`:
  - Sets `acc <= 0` and `sat <= 0`.
  - If it arrives together with a valid SINGLE update, `acc <= prod` (clear-and-load). `sat` then reflects only that cycle's result.
  - In SA mode, `acc_clr` clears `sat` before the SA saturation check is applied; a saturating SA add in the same cycle leaves `sat` = 1.
- `acc` and `weight` are retained across mode changes. Only `rst` or `acc_clr` clears `acc`; only `rst` or LOAD changes `weight`.
- Invalid cycles in modes 0–2 leave `acc`, `psum`, `weight` and `pe_out` unchanged; `out_valid` = 0.

## Timing
- Reset values: every register and output is 0, `sat` = 0, `mode_q` = IDLE.
- Reset asserted mid-accumulation discards all state immediately, asynchronously.
- Latency from `in_valid` at edge N:
  - `pe_out` and `out_valid` update at edge N (visible in cycle N+1).
  - `in_data_o`/`in_valid_o` and `psum_o` also update at edge N: one cycle per PE hop.
- `out_valid` is high for exactly one cycle per accepted valid input in modes 0–2. There is no back-pressure; the upstream must not exceed one input per cycle.
- `mode_i` is sampled every cycle and can change cycle to cycle. The operation in cycle N uses `mode_i` of cycle N. In a SINGLE→SA switch the first SA result does not use `acc`.
- `sat` is set on the edge where clamping occurs and stays high until `acc_clr` or `rst`.

## Test plan
- Reset, then hold IDLE with `in_valid` = 1 for 3 cycles → all outputs 0, `out_valid` = 0, `sat` = 0.
- SINGLE, DATA_W=8: inputs (3,4), (-2,5), (7,-1) on consecutive valid cycles → `pe_out` = 12, 2, -5, `out_valid` high each cycle. Then `acc_clr` with (2,2) → `pe_out` = 4.
- LOAD `in_filter` = -3, then SA with `in_data` = 6, `psum_i` = 100 → `psum_o` = `pe_out` = 82. `in_data_o` = 6 and `in_valid_o` = 1 one cycle after the input.
- Saturation, ACC_W=16: repeated SINGLE (127,127) until the sum exceeds 32767 → `pe_out` holds at 32767 and `sat` = 1. Then (-128,127) → `pe_out` = 16511, `sat` stays 1 until `acc_clr`.
- Gaps and mode interleave: SINGLE accumulate to 12, then SA cycle, IDLE cycle, invalid SINGLE cycle, then SINGLE (1,1) → `acc` = 13. `weight` is unchanged, and `out_valid` is 0 on the IDLE and invalid cycles.
- Assert async `rst` between clock edges during accumulation → `acc`, `pe_out` and `sat` go to 0 immediately. The first post-reset SINGLE (2,3) gives 6.

Source files
------------

// File: rtl/pe_mac_array_cell.sv
// Signed multiply-accumulate processing element for the weight-stationary systolic array.
// Runs as a stand-alone MAC (SINGLE) or as an array cell chaining partial sums (SA).
module pe_mac_array_cell #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_i,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_filter,
  input  logic [ACC_W-1:0]  psum_i,
  input  logic              acc_clr,
  output logic [DATA_W-1:0] in_data_o,
  output logic              in_valid_o,
  output logic [ACC_W-1:0]  psum_o,
  output logic [ACC_W-1:0]  pe_out,
  output logic              out_valid,
  output logic              sat
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SA     = 2'd1;
  localparam logic [1:0] MODE_LOAD   = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [DATA_W-1:0] weight_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic signed [DATA_W-1:0] data_s_c;
  logic signed [DATA_W-1:0] operand_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  prod_ext_c;
  logic signed [ACC_W-1:0]  base_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic                     ovf_c;
  logic [ACC_W-1:0]         sum_sat_c;

  logic [DATA_W-1:0] weight_d;
  logic [ACC_W-1:0]  acc_d;
  logic [ACC_W-1:0]  psum_d;
  logic [DATA_W-1:0] fwd_data_d;
  logic              fwd_valid_d;
  logic [ACC_W-1:0]  pe_out_d;
  logic              out_valid_d;
  logic              sat_d;

  // Shared multiplier and saturating adder; the addend base depends on the mode.
  // A clear in SINGLE mode zeroes the base so the same adder performs clear-and-load.
  always_comb begin
    data_s_c   = $signed(in_data);
    operand_c  = (mode_i == MODE_SINGLE) ? $signed(in_filter) : weight_q;
    prod_c     = PROD_W'(data_s_c) * PROD_W'(operand_c);
    prod_ext_c = ACC_W'(prod_c);
    if (mode_i == MODE_SA) begin
      base_c = $signed(psum_i);
    end else if (acc_clr) begin
      base_c = '0;
    end else begin
      base_c = acc_q;
    end
    sum_c = SUM_W'(base_c) + SUM_W'(prod_ext_c);
    ovf_c = sum_c[SUM_W-1] ^ sum_c[SUM_W-2];
    if (ovf_c) begin
      sum_sat_c = sum_c[SUM_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_sat_c = sum_c[ACC_W-1:0];
    end
  end

  // Next-state selection; IDLE falls through with every register holding.
  always_comb begin
    weight_d    = weight_q;
    acc_d       = acc_q;
    psum_d      = psum_o;
    fwd_data_d  = in_data_o;
    fwd_valid_d = in_valid_o;
    pe_out_d    = pe_out;
    out_valid_d = 1'b0;
    sat_d       = sat;

    if (acc_clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end

    case (mode_i)
      MODE_SINGLE: begin
        fwd_data_d  = in_data;
        fwd_valid_d = in_valid;
        if (in_valid) begin
          acc_d       = sum_sat_c;
          pe_out_d    = sum_sat_c;
          sat_d       = sat_d | ovf_c;
          out_valid_d = 1'b1;
        end
      end
      MODE_SA: begin
        fwd_data_d  = in_data;
        fwd_valid_d = in_valid;
        if (in_valid) begin
          psum_d      = sum_sat_c;
          pe_out_d    = sum_sat_c;
          sat_d       = sat_d | ovf_c;
          out_valid_d = 1'b1;
        end
      end
      MODE_LOAD: begin
        fwd_data_d  = in_data;
        fwd_valid_d = in_valid;
        if (in_valid) begin
          weight_d    = in_filter;
          pe_out_d    = ACC_W'($signed(in_filter));
          out_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_q   <= '0;
      acc_q      <= '0;
      psum_o     <= '0;
      in_data_o  <= '0;
      in_valid_o <= 1'b0;
      pe_out     <= '0;
      out_valid  <= 1'b0;
      sat        <= 1'b0;
    end else begin
      weight_q   <= weight_d;
      acc_q      <= acc_d;
      psum_o     <= psum_d;
      in_data_o  <= fwd_data_d;
      in_valid_o <= fwd_valid_d;
      pe_out     <= pe_out_d;
      out_valid  <= out_valid_d;
      sat        <= sat_d;
    end
  end

endmodule

// File: tb/tb_pe_mac_array_cell.sv
// Bench for pe_mac_array_cell: directed scenarios plus randomized traffic
// checked against an integer-arithmetic reference model.
module tb_pe_mac_array_cell;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACC_W - 1));

  logic              clk;
  logic              rst;
  logic [1:0]        mode_i;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_filter;
  logic [ACC_W-1:0]  psum_i;
  logic              acc_clr;
  logic [DATA_W-1:0] in_data_o;
  logic              in_valid_o;
  logic [ACC_W-1:0]  psum_o;
  logic [ACC_W-1:0]  pe_out;
  logic              out_valid;
  logic              sat;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_weight, m_acc, m_psum, m_pe, m_fd;
  bit m_fv, m_ov, m_sat;

  pe_mac_array_cell #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .in_valid(in_valid),
    .in_data(in_data), .in_filter(in_filter), .psum_i(psum_i), .acc_clr(acc_clr),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .psum_o(psum_o),
    .pe_out(pe_out), .out_valid(out_valid), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp(input int s, output bit o);
    o = 1'b0;
    if (s > ACC_MAX) begin o = 1'b1; return ACC_MAX; end
    if (s < ACC_MIN) begin o = 1'b1; return ACC_MIN; end
    return s;
  endfunction

  task automatic model_reset();
    m_weight = 0; m_acc = 0; m_psum = 0; m_pe = 0; m_fd = 0;
    m_fv = 1'b0; m_ov = 1'b0; m_sat = 1'b0;
  endtask

  task automatic model_step();
    int d, f, p;
    bit o;
    d = $signed(in_data);
    f = $signed(in_filter);
    p = $signed(psum_i);
    m_ov = 1'b0;
    if (acc_clr) begin m_acc = 0; m_sat = 1'b0; end
    case (mode_i)
      2'd0: if (in_valid) begin
        m_acc = clamp(m_acc + d * f, o); m_pe = m_acc; m_sat |= o; m_ov = 1'b1;
      end
      2'd1: if (in_valid) begin
        m_psum = clamp(p + d * m_weight, o); m_pe = m_psum; m_sat |= o; m_ov = 1'b1;
      end
      2'd2: if (in_valid) begin
        m_weight = f; m_pe = f; m_ov = 1'b1;
      end
      default: ;
    endcase
    if (mode_i != 2'd3) begin m_fd = d; m_fv = in_valid; end
  endtask

  task automatic apply(input logic [1:0] m, input bit v, input int d, input int f,
                       input int p, input bit clr);
    mode_i = m; in_valid = v; in_data = DATA_W'(d); in_filter = DATA_W'(f);
    psum_i = ACC_W'(p); acc_clr = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode_i = 2'd3; in_valid = 1'b0; in_data = '0; in_filter = '0; psum_i = '0; acc_clr = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if ({pe_out, psum_o, in_data_o, in_valid_o, out_valid, sat} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: pe_out=%0d psum_o=%0d in_data_o=%0d in_valid_o=%b out_valid=%b sat=%b, required all 0",
               pe_out, psum_o, in_data_o, in_valid_o, out_valid, sat);
    end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(2'd3, 1'b1, 5, 3, 7, 1'b0);
      n_checks++;
      if ({pe_out, psum_o, in_data_o, in_valid_o, out_valid, sat} !== '0) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: pe_out=%0d psum_o=%0d in_data_o=%0d in_valid_o=%b out_valid=%b sat=%b, required all 0",
                 i, pe_out, psum_o, in_data_o, in_valid_o, out_valid, sat);
      end
    end
  endtask

  task automatic test_single();
    int d[4]   = '{3, -2, 7, 2};
    int f[4]   = '{4, 5, -1, 2};
    int exp[4] = '{12, 2, -5, 4};
    for (int i = 0; i < 4; i++) begin
      apply(2'd0, 1'b1, d[i], f[i], 0, i == 3);
      n_checks++;
      if ($signed(pe_out) !== exp[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL single_mac[%0d]: pe_out=%0d out_valid=%b, required %0d/1",
                 i, $signed(pe_out), out_valid, exp[i]);
      end
    end
  endtask

  task automatic test_load_sa();
    apply(2'd2, 1'b1, 0, -3, 0, 1'b0);
    n_checks++;
    if ($signed(pe_out) !== -3 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL load_weight: pe_out=%0d out_valid=%b, required -3/1", $signed(pe_out), out_valid);
    end
    apply(2'd1, 1'b1, 6, 0, 100, 1'b0);
    n_checks++;
    if ($signed(psum_o) !== 82 || $signed(pe_out) !== 82 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sa_psum: psum_o=%0d pe_out=%0d out_valid=%b, required 82/82/1",
               $signed(psum_o), $signed(pe_out), out_valid);
    end
    n_checks++;
    if (in_data_o !== 8'd6 || in_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sa_forward: in_data_o=%0d in_valid_o=%b, required 6/1", in_data_o, in_valid_o);
    end
  endtask

  task automatic test_saturation();
    int exp[3]  = '{16129, 32258, 32767};
    bit sexp[3] = '{1'b0, 1'b0, 1'b1};
    apply(2'd0, 1'b0, 0, 0, 0, 1'b1);
    n_checks++;
    if (sat !== 1'b0 || out_valid !== 1'b0 || $signed(pe_out) !== 82) begin
      n_fail++;
      $display("FAIL clr_invalid: sat=%b out_valid=%b pe_out=%0d, required 0/0/82",
               sat, out_valid, $signed(pe_out));
    end
    for (int i = 0; i < 3; i++) begin
      apply(2'd0, 1'b1, 127, 127, 0, 1'b0);
      n_checks++;
      if ($signed(pe_out) !== exp[i] || sat !== sexp[i]) begin
        n_fail++;
        $display("FAIL sat_accum[%0d]: pe_out=%0d sat=%b, required %0d/%b",
                 i, $signed(pe_out), sat, exp[i], sexp[i]);
      end
    end
    apply(2'd0, 1'b1, -128, 127, 0, 1'b0);
    n_checks++;
    if ($signed(pe_out) !== 16511 || sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_recover: pe_out=%0d sat=%b, required 16511/1", $signed(pe_out), sat);
    end
    apply(2'd0, 1'b0, 0, 0, 0, 1'b0);
    n_checks++;
    if (sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_sticky: sat=%b, required 1", sat);
    end
    apply(2'd3, 1'b0, 0, 0, 0, 1'b1);
    n_checks++;
    if (sat !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear_idle: sat=%b, required 0", sat);
    end
  endtask

  task automatic test_interleave();
    apply(2'd0, 1'b1, 3, 4, 0, 1'b1);
    n_checks++;
    if ($signed(pe_out) !== 12) begin
      n_fail++;
      $display("FAIL clear_and_load: pe_out=%0d, required 12", $signed(pe_out));
    end
    apply(2'd1, 1'b1, 1, 0, 5, 1'b0);
    n_checks++;
    if ($signed(pe_out) !== 2 || $signed(psum_o) !== 2) begin
      n_fail++;
      $display("FAIL sa_no_acc: pe_out=%0d psum_o=%0d, required 2/2", $signed(pe_out), $signed(psum_o));
    end
    apply(2'd3, 1'b1, 9, 9, 9, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || $signed(pe_out) !== 2 || in_data_o !== 8'd1 || in_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_gap: out_valid=%b pe_out=%0d in_data_o=%0d in_valid_o=%b, required 0/2/1/1",
               out_valid, $signed(pe_out), in_data_o, in_valid_o);
    end
    apply(2'd0, 1'b0, 4, 4, 0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || $signed(pe_out) !== 2 || in_data_o !== 8'd4 || in_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_gap: out_valid=%b pe_out=%0d in_data_o=%0d in_valid_o=%b, required 0/2/4/0",
               out_valid, $signed(pe_out), in_data_o, in_valid_o);
    end
    apply(2'd0, 1'b1, 1, 1, 0, 1'b0);
    n_checks++;
    if ($signed(pe_out) !== 13 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL acc_retained: pe_out=%0d out_valid=%b, required 13/1", $signed(pe_out), out_valid);
    end
    apply(2'd1, 1'b1, 1, 0, 0, 1'b0);
    n_checks++;
    if ($signed(pe_out) !== -3) begin
      n_fail++;
      $display("FAIL weight_retained: pe_out=%0d, required -3", $signed(pe_out));
    end
  endtask

  task automatic test_async_reset();
    apply(2'd0, 1'b1, 127, 127, 0, 1'b1);
    apply(2'd0, 1'b1, 127, 127, 0, 1'b0);
    apply(2'd0, 1'b1, 127, 127, 0, 1'b0);
    n_checks++;
    if (sat !== 1'b1 || $signed(pe_out) !== 32767) begin
      n_fail++;
      $display("FAIL pre_reset_sat: sat=%b pe_out=%0d, required 1/32767", sat, $signed(pe_out));
    end
    #3 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({pe_out, psum_o, out_valid, sat} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: pe_out=%0d psum_o=%0d out_valid=%b sat=%b, required all 0",
               pe_out, psum_o, out_valid, sat);
    end
    @(negedge clk) rst = 1'b0;
    apply(2'd0, 1'b1, 2, 3, 0, 1'b0);
    n_checks++;
    if ($signed(pe_out) !== 6 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_mac: pe_out=%0d sat=%b, required 6/0", $signed(pe_out), sat);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 65535)), $urandom_range(0, 15) == 0);
      n_checks++;
      if ($signed(pe_out) !== m_pe || $signed(psum_o) !== m_psum || out_valid !== m_ov ||
          sat !== m_sat || $signed(in_data_o) !== m_fd || in_valid_o !== m_fv) begin
        n_fail++;
        $display("FAIL random[%0d]: pe_out=%0d psum_o=%0d ov=%b sat=%b fd=%0d fv=%b, required %0d/%0d/%b/%b/%0d/%b",
                 i, $signed(pe_out), $signed(psum_o), out_valid, sat, $signed(in_data_o), in_valid_o,
                 m_pe, m_psum, m_ov, m_sat, m_fd, m_fv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_load_sa();
    test_saturation();
    test_interleave();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
